// File: rtl/bus_copy_master_if.sv
// Bus: HighRisc data bus connection. Master drives address/write side,
// slave returns read data one cycle after the address.
interface Bus #(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 16
);
  logic [AddressWidth-1:0] Address;
  logic [DataWidth-1:0]    WriteData;
  logic                    WriteEnable;
  logic [DataWidth-1:0]    ReadData;

  modport Master (
    output Address,
    output WriteData,
    output WriteEnable,
    input  ReadData
  );

  modport Slave (
    input  Address,
    input  WriteData,
    input  WriteEnable,
    output ReadData
  );
endinterface

// File: rtl/bus_copy_master.sv
// bus_copy_master: bus-master DMA engine that copies a run of words
// between address ranges or fills a range with a constant value.
module bus_copy_master #(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  Bus.Master                      TheBus,
  input  logic                    Start,
  input  logic                    Mode,
  input  logic [AddressWidth-1:0] SrcAddr,
  input  logic [AddressWidth-1:0] DstAddr,
  input  logic [15:0]             Length,
  input  logic [DataWidth-1:0]    FillValue,
  input  logic                    Abort,
  input  logic                    BusGrant,
  output logic                    BusReq,
  output logic                    Busy,
  output logic                    Done,
  output logic [15:0]             WordsLeft
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [AddressWidth-1:0] src_q, src_d;
  logic [AddressWidth-1:0] dst_q, dst_d;
  logic [DataWidth-1:0]    fill_q, fill_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic [15:0]             words_q, words_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    data_d  = data_q;
    words_d = words_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          fill_d  = FillValue;
          words_d = Length;
          state_d = (Length == 16'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (BusGrant)
          state_d = mode_q ? S_FILL : S_READ;
      end
      S_FILL: begin
        if (BusGrant) begin
          dst_d   = dst_q + 1'b1;
          words_d = words_q - 16'd1;
          if (words_q == 16'd1)
            state_d = S_DONE;
        end
      end
      S_READ: begin
        if (BusGrant)
          state_d = S_WAIT;
      end
      // slave already holds the address from READ; no grant needed
      S_WAIT: begin
        data_d  = TheBus.ReadData;
        src_d   = src_q + 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (BusGrant) begin
          dst_d   = dst_q + 1'b1;
          words_d = words_q - 16'd1;
          state_d = (words_q == 16'd1) ? S_DONE : S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (Abort && state_q != S_IDLE && state_q != S_DONE)
      state_d = S_IDLE;
  end

  always_comb begin
    TheBus.Address     = '0;
    TheBus.WriteData   = '0;
    TheBus.WriteEnable = 1'b0;
    if (BusGrant) begin
      unique case (state_q)
        S_FILL: begin
          TheBus.Address     = dst_q;
          TheBus.WriteData   = fill_q;
          TheBus.WriteEnable = 1'b1;
        end
        S_READ: TheBus.Address = src_q;
        S_WRITE: begin
          TheBus.Address     = dst_q;
          TheBus.WriteData   = data_q;
          TheBus.WriteEnable = 1'b1;
        end
        default: ;
      endcase
    end
    BusReq    = (state_q == S_REQ)  || (state_q == S_FILL) ||
                (state_q == S_READ) || (state_q == S_WAIT) ||
                (state_q == S_WRITE);
    Busy      = (state_q != S_IDLE);
    Done      = (state_q == S_DONE);
    WordsLeft = words_q;
  end

endmodule

// File: tb/tb_bus_copy_master.sv
// tb_bus_copy_master: directed fill/copy/abort/reset scenarios with a
// queued expectation list checked by an independent bus monitor.
module tb_bus_copy_master;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Start, Mode, Abort, BusGrant;
  logic [15:0] SrcAddr, DstAddr, Length, FillValue;
  logic        BusReq, Busy, Done;
  logic [15:0] WordsLeft;

  Bus #(.AddressWidth(16), .DataWidth(16)) bus ();

  bus_copy_master #(.AddressWidth(16), .DataWidth(16)) dut (
    .Clock(clk),
    .Reset(Reset),
    .TheBus(bus),
    .Start(Start),
    .Mode(Mode),
    .SrcAddr(SrcAddr),
    .DstAddr(DstAddr),
    .Length(Length),
    .FillValue(FillValue),
    .Abort(Abort),
    .BusGrant(BusGrant),
    .BusReq(BusReq),
    .Busy(Busy),
    .Done(Done),
    .WordsLeft(WordsLeft)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] mem [65536];
  int          cyc = 0;
  int          base = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          req_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // one-cycle-latency slave memory
  always @(posedge clk) begin
    bus.ReadData <= mem[bus.Address];
    if (bus.WriteEnable) mem[bus.Address] = bus.WriteData;
  end

  always @(negedge clk) begin
    ev_t e;
    if (!Reset) begin
      if (BusReq) req_seen = 1;
      if (bus.WriteEnable || Done) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event done=%0b cyc=%0d addr=%h data=%h required=none",
                   Done, cyc - base, bus.Address, bus.WriteData);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != int'(Done) || e.cyc != cyc - base ||
              e.addr !== bus.Address || e.data !== bus.WriteData) begin
            n_fail++;
            $display("FAIL bus_event got done=%0b cyc=%0d addr=%h data=%h required done=%0d cyc=%0d addr=%h data=%h",
                     Done, cyc - base, bus.Address, bus.WriteData,
                     e.kind, e.cyc, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic go(input logic m, input logic [15:0] s, input logic [15:0] d,
                    input logic [15:0] len, input logic [15:0] fv);
    @(posedge clk); #1;
    Mode = m; SrcAddr = s; DstAddr = d; Length = len; FillValue = fv;
    Start = 1;
    @(posedge clk); #1;
    base = cyc - 1;
    Start = 0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int k = 0;
    do begin
      @(negedge clk); #2;
      k++;
    end while ((Busy || exp_q.size() != 0) && k < lim);
    chk({nm, "_complete"}, {31'd0, k >= lim, exp_q.size()}, 64'd0);
    exp_q.delete();
  endtask

  initial begin
    Reset = 1; Start = 0; Mode = 0; Abort = 0; BusGrant = 1;
    SrcAddr = 0; DstAddr = 0; Length = 0; FillValue = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    #12;
    chk("reset_outputs",
        {BusReq, Busy, Done, WordsLeft, bus.Address, bus.WriteData, bus.WriteEnable},
        64'd0);
    Reset = 0;

    // fill 4 words
    for (int i = 0; i < 4; i++) push(0, 2 + i, 16'h4000 + 16'(i), 16'h00E3);
    push(1, 6, 16'h0, 16'h0);
    go(1'b1, 16'h0, 16'h4000, 16'd4, 16'h00E3);
    wait_idle("fill", 40);
    chk("fill_wordsleft", WordsLeft, 16'd0);

    // copy 3 words
    mem[16'h0010] = 16'h1111; mem[16'h0011] = 16'h2222; mem[16'h0012] = 16'h3333;
    push(0, 4, 16'h4010, 16'h1111);
    push(0, 7, 16'h4011, 16'h2222);
    push(0, 10, 16'h4012, 16'h3333);
    push(1, 11, 16'h0, 16'h0);
    go(1'b0, 16'h0010, 16'h4010, 16'd3, 16'h0);
    wait_idle("copy", 40);
    chk("copy_mem0", mem[16'h4010], 16'h1111);
    chk("copy_mem1", mem[16'h4011], 16'h2222);
    chk("copy_mem2", mem[16'h4012], 16'h3333);

    // copy with grant low during the second write
    push(0, 4, 16'h4020, 16'h1111);
    push(0, 9, 16'h4021, 16'h2222);
    push(0, 12, 16'h4022, 16'h3333);
    push(1, 13, 16'h0, 16'h0);
    go(1'b0, 16'h0010, 16'h4020, 16'd3, 16'h0);
    repeat (6) @(posedge clk);
    #1 BusGrant = 0;
    repeat (2) @(posedge clk);
    #1 BusGrant = 1;
    wait_idle("dropout", 40);
    chk("dropout_mem1", mem[16'h4021], 16'h2222);

    // zero length
    req_seen = 0;
    push(1, 1, 16'h0, 16'h0);
    go(1'b1, 16'h0, 16'h4000, 16'd0, 16'h1234);
    wait_idle("zero_len", 10);
    chk("zero_len_no_busreq", {63'd0, req_seen}, 64'd0);

    // fill across the address wrap
    push(0, 2, 16'hFFFF, 16'h5A5A);
    push(0, 3, 16'h0000, 16'h5A5A);
    push(1, 4, 16'h0, 16'h0);
    go(1'b1, 16'h0, 16'hFFFF, 16'd2, 16'h5A5A);
    wait_idle("wrap", 20);
    chk("wrap_mem0", mem[16'h0000], 16'h5A5A);

    // abort during fill
    for (int i = 0; i < 3; i++) push(0, 2 + i, 16'h4000 + 16'(i), 16'h0077);
    go(1'b1, 16'h0, 16'h4000, 16'd8, 16'h0077);
    repeat (3) @(posedge clk);
    #1 Abort = 1;
    @(posedge clk);
    #1 Abort = 0;
    chk("abort_idle_busy", {63'd0, Busy}, 64'd0);
    chk("abort_wordsleft", WordsLeft, 16'd5);
    repeat (4) @(posedge clk);
    #1 chk("abort_events_left", exp_q.size(), 64'd0);
    chk("abort_no_4th_write", mem[16'h4003], 16'h00E3);
    exp_q.delete();

    // reset mid-copy
    push(0, 4, 16'h4030, 16'h1111);
    go(1'b0, 16'h0010, 16'h4030, 16'd3, 16'h0);
    repeat (4) @(posedge clk);
    #3 Reset = 1;
    #1 chk("midreset_outputs",
           {BusReq, Busy, Done, WordsLeft, bus.Address, bus.WriteData, bus.WriteEnable},
           64'd0);
    repeat (2) @(posedge clk);
    #1 Reset = 0;
    repeat (5) @(posedge clk);
    #1 chk("midreset_events_left", exp_q.size(), 64'd0);
    chk("midreset_no_write", mem[16'h4031], 16'h0);
    exp_q.delete();

    push(0, 2, 16'h4040, 16'hBEEF);
    push(0, 3, 16'h4041, 16'hBEEF);
    push(1, 4, 16'h0, 16'h0);
    go(1'b1, 16'h0, 16'h4040, 16'd2, 16'hBEEF);
    wait_idle("after_reset", 20);
    chk("after_reset_mem", mem[16'h4041], 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
